template_stream_source: RTL

- Synthesizable stimulus master for the `template` data interface: drives `input_data`/`enable` exactly as the `template` block consumes them.
- Generates programmable bursts of counter or LFSR words with idle gaps between bursts.
- Sits in front of `template` in self-checking FPGA builds and in the `template` testbench, replacing behavioural stimulus.

---
 rtl/template_stream_source.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/template_stream_source.sv
// Burst stimulus master for the `template` data interface: counter or Galois-LFSR words with idle gaps.
// Optional `checksum` output is enabled by defining TEMPLATE_STREAM_SOURCE_CHECKSUM_EN.
module template_stream_source #(
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    COUNT_WIDTH = 16,
  parameter int                    GAP_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] SEED        = 16'h0001,
  parameter logic [DATA_WIDTH-1:0] POLY        = 16'hB400
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   mode,
  input  logic [COUNT_WIDTH-1:0] burst_len,
  input  logic [GAP_WIDTH-1:0]   gap_len,
  input  logic [7:0]             num_bursts,
  input  logic                   abort,
  output logic [DATA_WIDTH-1:0]  input_data,
  output logic                   enable,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] word_count
`ifdef TEMPLATE_STREAM_SOURCE_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]  checksum
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [DATA_WIDTH-1:0]  DATA_ONE = DATA_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
  localparam logic [GAP_WIDTH-1:0]   GAP_ONE  = GAP_WIDTH'(1);
  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [DATA_WIDTH-1:0]  SEED_EFF = (SEED == '0) ? DATA_ONE : SEED;

  function automatic logic [DATA_WIDTH-1:0] gen_next(input logic m, input logic [DATA_WIDTH-1:0] x);
    if (m) begin
      gen_next = (x >> 1) ^ (x[0] ? POLY : {DATA_WIDTH{1'b0}});
    end else begin
      gen_next = x + DATA_ONE;
    end
  endfunction

  state_t                 state_q, state_d;
  logic                   mode_q, mode_d;
  logic [COUNT_WIDTH-1:0] len_q, len_d;
  logic [GAP_WIDTH-1:0]   gap_q, gap_d;
  logic [7:0]             bursts_left_q, bursts_left_d;
  logic [COUNT_WIDTH-1:0] beat_q, beat_d;
  logic [GAP_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0]  gen_q, gen_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   enable_q, enable_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [COUNT_WIDTH-1:0] wc_q, wc_d;
  logic [DATA_WIDTH-1:0]  first_s;
`ifdef TEMPLATE_STREAM_SOURCE_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]  csum_q, csum_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      mode_q        <= 1'b0;
      len_q         <= '0;
      gap_q         <= '0;
      bursts_left_q <= 8'd0;
      beat_q        <= '0;
      gap_cnt_q     <= '0;
      gen_q         <= SEED_EFF;
      data_q        <= '0;
      enable_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      wc_q          <= '0;
`ifdef TEMPLATE_STREAM_SOURCE_CHECKSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      len_q         <= len_d;
      gap_q         <= gap_d;
      bursts_left_q <= bursts_left_d;
      beat_q        <= beat_d;
      gap_cnt_q     <= gap_cnt_d;
      gen_q         <= gen_d;
      data_q        <= data_d;
      enable_q      <= enable_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      wc_q          <= wc_d;
`ifdef TEMPLATE_STREAM_SOURCE_CHECKSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

  // Outputs are next-cycle values: enable_d/data_d describe the word presented after this edge.
  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    len_d         = len_q;
    gap_d         = gap_q;
    bursts_left_d = bursts_left_q;
    beat_d        = beat_q;
    gap_cnt_d     = gap_cnt_q;
    gen_d         = gen_q;
    data_d        = '0;
    enable_d      = 1'b0;
    busy_d        = busy_q;
    done_d        = 1'b0;
    wc_d          = wc_q;
    first_s       = mode ? SEED_EFF : {DATA_WIDTH{1'b0}};
`ifdef TEMPLATE_STREAM_SOURCE_CHECKSUM_EN
    csum_d        = csum_q;
`endif

    if (enable_q) begin
      wc_d = wc_q + CNT_ONE;
`ifdef TEMPLATE_STREAM_SOURCE_CHECKSUM_EN
      csum_d = csum_q ^ data_q;
`endif
    end else begin
      wc_d = wc_q;
    end

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          mode_d        = mode;
          len_d         = burst_len;
          gap_d         = gap_len;
          bursts_left_d = (num_bursts == 8'd0) ? 8'd0 : (num_bursts - 8'd1);
          wc_d          = '0;
          busy_d        = 1'b1;
          beat_d        = '0;
`ifdef TEMPLATE_STREAM_SOURCE_CHECKSUM_EN
          csum_d        = '0;
`endif
          if (burst_len == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
            gen_d   = first_s;
          end else begin
            state_d  = BURST;
            enable_d = 1'b1;
            data_d   = first_s;
            gen_d    = gen_next(mode, first_s);
          end
        end else begin
          state_d = IDLE;
        end
      end
      BURST: begin
        if (beat_q == (len_q - CNT_ONE)) begin
          if (bursts_left_q != 8'd0) begin
            bursts_left_d = bursts_left_q - 8'd1;
            beat_d        = '0;
            if (gap_q != '0) begin
              state_d   = GAP;
              gap_cnt_d = gap_q;
            end else begin
              enable_d = 1'b1;
              data_d   = gen_q;
              gen_d    = gen_next(mode_q, gen_q);
            end
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          beat_d   = beat_q + CNT_ONE;
          enable_d = 1'b1;
          data_d   = gen_q;
          gen_d    = gen_next(mode_q, gen_q);
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_ONE) begin
          state_d  = BURST;
          enable_d = 1'b1;
          data_d   = gen_q;
          gen_d    = gen_next(mode_q, gen_q);
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Abort wins over everything else once a run is in progress; word_count keeps its value.
    if (abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      enable_d = 1'b0;
      data_d   = '0;
      busy_d   = 1'b0;
      done_d   = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  assign input_data = data_q;
  assign enable     = enable_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign word_count = wc_q;
`ifdef TEMPLATE_STREAM_SOURCE_CHECKSUM_EN
  assign checksum   = csum_q;
`endif

endmodule
